d_cache_responder: RTL

//  Responder end of the reservation-station -> data-cache request interface (valid/mem_action/addr/data).

---
 rtl/d_cache_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/d_cache_responder.sv
// rtl/d_cache_responder.sv - direct-mapped write-through data cache responder
// Serves loads from a one-word-per-line cache and forwards misses and all stores to a req/ack memory.
module d_cache_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROB_DEPTH_BITS = 4,
  parameter int INDEX_BITS     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [ROB_DEPTH_BITS-1:0] req_tag,
  input  logic                      flush,
  output logic                      stall,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic [ROB_DEPTH_BITS-1:0] resp_tag,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t                    state;
  logic [LINES-1:0]          line_valid;
  logic [TAG_W-1:0]          line_tag  [LINES];
  logic [DATA_WIDTH-1:0]     line_data [LINES];
  logic [ROB_DEPTH_BITS-1:0] pend_tag;
  logic                      flushed;

  logic [INDEX_BITS-1:0]     req_idx;
  logic [TAG_W-1:0]          req_ltag;
  logic [INDEX_BITS-1:0]     mem_idx;
  logic [TAG_W-1:0]          mem_ltag;
  logic                      hit;
  logic                      unused_addr_lsb;

  assign req_idx         = req_addr[INDEX_BITS+1:2];
  assign req_ltag        = req_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign mem_idx         = mem_addr[INDEX_BITS+1:2];
  assign mem_ltag        = mem_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit             = line_valid[req_idx] && (line_tag[req_idx] == req_ltag);
  assign unused_addr_lsb = ^{req_addr[1:0], mem_addr[1:0]};

  assign stall = (state == IDLE) ? (req_valid && (req_write || !hit)) : !mem_ack;

  // Line storage is not reset; line_valid alone decides whether contents are meaningful.
  logic                  arr_we;
  logic [INDEX_BITS-1:0] arr_idx;
  logic [TAG_W-1:0]      arr_tag;
  logic [DATA_WIDTH-1:0] arr_data;

  always_comb begin
    arr_we   = 1'b0;
    arr_idx  = req_idx;
    arr_tag  = req_ltag;
    arr_data = req_wdata;
    if (state == IDLE && req_valid && req_write && hit) begin
      arr_we = 1'b1;
    end else if (state == REFILL && mem_ack) begin
      arr_we   = 1'b1;
      arr_idx  = mem_idx;
      arr_tag  = mem_ltag;
      arr_data = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && arr_we) begin
      line_tag[arr_idx]  <= arr_tag;
      line_data[arr_idx] <= arr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      line_valid <= '0;
      pend_tag   <= '0;
      flushed    <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= req_wdata;
            state     <= WRITE;
          end else if (req_valid && hit) begin
            resp_valid <= !flush;
            resp_data  <= line_data[req_idx];
            resp_tag   <= req_tag;
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
          end else if (req_valid) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            pend_tag <= req_tag;
            flushed  <= 1'b0;
            state    <= REFILL;
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
          end
        end
        REFILL: begin
          if (flush) flushed <= 1'b1;
          if (mem_ack) begin
            line_valid[mem_idx] <= 1'b1;
            mem_req    <= 1'b0;
            resp_valid <= !(flushed || flush);
            resp_data  <= mem_rdata;
            resp_tag   <= pend_tag;
            state      <= IDLE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
